contador_vga: RTL
=================

Name: contador_vga

Overview:
- Free-running VGA raster timing counter; the stage directly upstream of the vertical-sync generator.
- Divides the system clock to a pixel tick.
- Counts horizontal pixels and vertical lines, and exports cntHorizontal/cntVertical (10 bits each) to the HSync/VSync generators and the pixel pipeline.
- Default timing is 640x480 @ 60 Hz from a 50 MHz clock: 800x525 pixel ticks x 2 clocks = 840 000 clocks per frame.

Parameters:
DIV, 2, system clocks per pixel tick (>=1)
H_TOTAL, 800, pixel ticks per line
V_TOTAL, 525, lines per frame
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
pixelTick  output  1  one-clk strobe every DIV clocks; counters advance on it
cntHorizontal  output  10  pixel index 0..H_TOTAL-1
cntVertical  output  10  line index 0..V_TOTAL-1
endLine  output  1  one-clk strobe on last pixel tick of a line
endFrame  output  1  one-clk strobe on last pixel tick of a frame
videoOn  output  1  high inside the active area

Behaviour:
- Reset: sampled on clk rising edge only. While high, the divider, cntHorizontal and cntVertical load 0 on the next edge.
- During reset: pixelTick, endLine and endFrame are 0, and videoOn is 1 (h=0, v=0 is active).
- Reset has priority over every other event, including mid-line and mid-frame assertion. No partial state survives reset.
- Divider: internal counter div, width clog2(DIV) (min 1 bit), counts 0..DIV-1 and wraps to 0.
- pixelTick = (div == DIV-1) && !reset, decoded combinationally from the register. With DIV=1, pixelTick is constantly 1 outside reset.
- Horizontal counter: on an edge with pixelTick=1, cntHorizontal increments. At H_TOTAL-1 it wraps to 0 instead.
- Vertical counter: increments only on the edge where cntHorizontal wraps. At V_TOTAL-1 it wraps to 0 on that same edge. Both wraps are simultaneous at frame end.
- Counters are 10-bit unsigned and never exceed TOTAL-1. No other values are reachable after reset.
- endLine = pixelTick && cntHorizontal == H_TOTAL-1.
- endFrame = endLine && cntVertical == V_TOTAL-1.
- videoOn = (cntHorizontal < H_ACTIVE) && (cntVertical < V_ACTIVE). Combinational from the registers, zero latency relative to the counters.
- Each cntHorizontal value is held for exactly DIV clocks, including the first value after reset release.
- Line period = H_TOTAL*DIV clocks; frame period = H_TOTAL*V_TOTAL*DIV clocks.
- Downstream contract: the VSync generator asserts VSync for cntVertical 1..523 and deasserts it for 0 and 524. This block must present every value 0..524 for exactly one line each.
- No handshake or backpressure; the block always runs.

Optional Feature:
- Macro: CONTADOR_FRAME_CNT_EN.
- Defined: adds output frameCount (8 bits, reset 0). It increments on every edge where endFrame=1 and wraps 255->0. Intended for blink/animation timing.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Hold reset 5 clks, DIV=2 -> all counters 0, pixelTick 0. After release, pixelTick is high on the 2nd clk and cntHorizontal reads 1 after the 2nd edge.
- Run 1600 clks from reset -> cntHorizontal goes 799->0, cntVertical goes 0->1, endLine is high for exactly 1 clk, endFrame stays 0.
- Run 840 000 clks -> cntVertical goes 524->0 together with cntHorizontal 799->0. endFrame is a single 1-clk pulse; the next endFrame comes 840 000 clks later. Attached VSync generator is low at v=0 and v=524, high at v=1..523.
- Assert reset at h=400, v=300 for 1 clk -> next edge gives h=0, v=0, div=0. Counting resumes normally from there.
- videoOn check -> h=639/v=479 gives 1; h=640/v=479 gives 0; h=0/v=480 gives 0; h=799/v=524 gives 0.
- With CONTADOR_FRAME_CNT_EN and DIV=1, H_TOTAL=4, V_TOTAL=2 -> frameCount increments every 8 clks and wraps 255->0 after 2048 clks.

Source files
------------

// File: rtl/contador_vga.sv
// VGA raster timing counter: divides clk to a pixel tick and walks the h/v raster.
// Optional frameCount output is enabled with `define CONTADOR_FRAME_CNT_EN.
module contador_vga #(
  parameter int DIV      = 2,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixelTick,
  output logic [9:0] cntHorizontal,
  output logic [9:0] cntVertical,
  output logic       endLine,
  output logic       endFrame,
`ifdef CONTADOR_FRAME_CNT_EN
  output logic [7:0] frameCount,
`endif
  output logic       videoOn
);

  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]      V_ACT    = 10'(V_ACTIVE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             tick_raw;
  logic             h_wrap;
  logic             v_wrap;

  always_comb begin
    tick_raw  = (div_q == DIV_LAST);
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    pixelTick = tick_raw && !reset;
    endLine   = pixelTick && h_wrap;
    endFrame  = endLine && v_wrap;
    videoOn   = (h_q < H_ACT) && (v_q < V_ACT);

    div_d = tick_raw ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick_raw) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      // vertical advances only on the same edge the line wraps
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
    end
    if (reset) begin
      div_d = '0;
      h_d   = 10'd0;
      v_d   = 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    div_q <= div_d;
    h_q   <= h_d;
    v_q   <= v_d;
  end

  assign cntHorizontal = h_q;
  assign cntVertical   = v_q;

`ifdef CONTADOR_FRAME_CNT_EN
  logic [7:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (endFrame) begin
      fc_d = fc_q + 8'd1;
    end
    if (reset) begin
      fc_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    fc_q <= fc_d;
  end

  assign frameCount = fc_q;
`endif

endmodule
